// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter with burst limit for the shared mem_io bus.
// Optional grant/conflict statistics counters are enabled with `define ARB_STATS_EN.
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
`ifdef ARB_STATS_EN
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1,
  output logic [15:0]   conflict_cnt,
  input  logic          stats_clr,
`endif
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d, burst_inc;
  logic          last_q, last_d;
  logic          pend0_q, pend1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + CW'(1);

  // Arbitration and owner/burst bookkeeping; no grant while in reset.
  always_comb begin
    state_d = IDLE;
    burst_d = '0;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        case (state_q)
          OWN0:    if (burst_q < BURST_MAX) gnt0 = 1'b1; else gnt1 = 1'b1;
          OWN1:    if (burst_q < BURST_MAX) gnt1 = 1'b1; else gnt0 = 1'b1;
          default: if (last_q) gnt0 = 1'b1; else gnt1 = 1'b1;
        endcase
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    if (gnt0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      burst_d = (state_q == OWN0) ? burst_inc : CW'(1);
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      burst_d = (state_q == OWN1) ? burst_inc : CW'(1);
    end
  end

  // Winner's request drives mem_io in the grant cycle.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = addr0;
      mem_din  = wdata0;
      mem_we   = we0;
    end else if (gnt1) begin
      mem_addr = addr1;
      mem_din  = wdata1;
      mem_we   = we1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      last_q   <= 1'b1;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      pend0_q <= gnt0 & ~we0;
      pend1_q <= gnt1 & ~we1;
      if (pend0_q) rdata0_q <= mem_dout;
      if (pend1_q) rdata1_q <= mem_dout;
    end
  end

  // mem_dout arrives in the cycle after the grant, so it is forwarded directly then held.
  assign rvalid0 = pend0_q;
  assign rvalid1 = pend1_q;
  assign rdata0  = pend0_q ? mem_dout : rdata0_q;
  assign rdata1  = pend1_q ? mem_dout : rdata1_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt1) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (req0 && req1) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter sharing the single mem_io address/data bus between the albacore processor (port 0) and a serial program-loader/debug master (port 1).
- Grants one access per cycle and forwards the winner's address, write data and write-enable to mem_io.
- Returns read data to the granted requester one cycle later.
- Uses round-robin with a burst limit so the loader cannot starve the processor, and the processor cannot starve the loader.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is requesting; legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req0  input  1  port 0 (processor) access request
- addr0  input  AW  port 0 address
- wdata0  input  DW  port 0 write data
- we0  input  1  port 0 write (1) / read (0)
- gnt0  output  1  port 0 access accepted this cycle
- rvalid0  output  1  port 0 read data valid
- rdata0  output  DW  port 0 read data
- req1, addr1, wdata1, we1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (loader)
- mem_addr  output  AW  address to mem_io
- mem_din  output  DW  write data to mem_io
- mem_we  output  1  write strobe to mem_io
- mem_dout  input  DW  read data from mem_io, valid one cycle after the address is presented

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low, on reset_n. While reset_n=0: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_we=0, mem_addr=0, mem_din=0, state=IDLE, burst_cnt=0, last_owner=1 (port 0 wins the first tie).
- States: IDLE (no grant last cycle), OWN0, OWN1. The state is registered and holds the owner of the previous cycle.
- Arbitration is combinational from req0/req1 and registered state:
  - No request: no grant; next state IDLE; burst_cnt=0.
  - One request: that port is granted.
  - Both request, state OWNx, burst_cnt<MAX_BURST: port x keeps the bus.
  - Both request, state OWNx, burst_cnt==MAX_BURST: the other port is granted.
  - Both request, state IDLE: the port that is not last_owner is granted.
- Grant bookkeeping:
  - burst_cnt=1 on a change of owner or on a grant from IDLE.
  - burst_cnt increments on a repeat grant to the same owner and saturates at MAX_BURST.
  - last_owner updates on every grant.
- Bus drive (combinational, same cycle as grant): mem_addr/mem_din/mem_we come from the granted port. mem_we=we of the winner, gated by grant. With no grant: mem_we=0, mem_addr=0, mem_din=0.
- gnt is one-hot or zero and is never asserted without the matching req.
- Requesters hold addr/we/wdata stable from req assertion until the cycle their gnt is high. They may drop or re-raise req at any time.
- Read return:
  - A granted read (we=0) sets a registered pending tag. The next cycle asserts rvalidx=1 with rdatax=mem_dout for exactly one cycle.
  - rdata of the other port holds its last value.
  - Writes produce no rvalid.
- Back-to-back: a new grant in the cycle rvalid is high for the previous read is legal; throughput is 1 access/cycle.
- Simultaneous events: a port may receive rvalid for a read and gnt for its next access in the same cycle.
- Reset mid-operation: a pending rvalid is discarded; no rvalid follows reset release.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds outputs:
  - grant_cnt0 (output, 16): count of port 0 grants.
  - grant_cnt1 (output, 16): count of port 1 grants.
  - conflict_cnt (output, 16): count of cycles with req0&req1 both high.
  - stats_clr (input, 1): synchronous clear, taking priority over increment in the same cycle.
- All counters wrap from 16'hFFFF to 0 and reset to 0 on reset_n.
- When not defined: these ports and their logic are absent, and arbitration behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with req0=req1=1 -> gnt0=gnt1=0, mem_we=0, rvalid0/1=0. Release reset -> the first cycle grants port 0.
- Single read: req0=1, addr0=16'h0010, we0=0, memory holds 16'hBEEF -> gnt0=1 with mem_addr=16'h0010 that cycle; next cycle rvalid0=1, rdata0=16'hBEEF; rvalid1 stays 0.
- Write passthrough: req1=1, addr1=16'h8002, wdata1=16'h00A5, we1=1 -> same cycle gnt1=1, mem_we=1, mem_addr=16'h8002, mem_din=16'h00A5; no rvalid1.
- Burst limit: MAX_BURST=4, req0 and req1 held high for 12 cycles starting with port 0 owning -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0; with ARB_STATS_EN, conflict_cnt=12, grant_cnt0=8, grant_cnt1=4.
- Reset mid-read: port 0 read granted, reset_n pulsed low before the next edge -> no rvalid0 after release; rdata0=0.
- Back-to-back reads: req0 high for 3 reads at addresses 1,2,3 -> rvalid0 high 3 consecutive cycles with data in address order; gnt0 overlaps rvalid0.
